logic_seq_unit: RTL and testbench
=================================

// Module: logic_seq_unit
// PURPOSE
//   Handshaked, multi-cycle bitwise logic engine; the responder for the ands/ors/nots stimulus stream.
//   Accepts one op + two operands via valid/ready, evaluates CHUNK bits per cycle, returns a
//   registered result with zero flag via valid/ready. Sits behind the ALU op dispatcher, beside
//   the arithmetic units, when area matters more than latency.
// PARAMETERS
//   WIDTH  8  operand/result width in bits
//   CHUNK  2  bits evaluated per BUSY cycle; 1 <= CHUNK <= WIDTH, WIDTH % CHUNK == 0 (else $fatal at elaboration)
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      request valid
//   in_ready   out  1      unit can accept a request
//   op         in   3      opcode (table below)
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B (ignored by NOT/PASS)
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer takes result
//   y          out  WIDTH  result
//   zero       out  1      y == 0, valid with out_valid
//   busy       out  1      state != IDLE
// BEHAVIOUR
//   Opcodes: 000 AND, 001 OR, 010 NOT a, 011 XOR, 100 NAND, 101 NOR, 110 XNOR, 111 PASS a.
//   Reset (rst_n=0, async): state=IDLE, in_ready=1, out_valid=0, busy=0, y=0, zero=0, chunk idx=0,
//     captured a/b/op=0. In-flight op is discarded; no output for it.
//   FSM IDLE -> BUSY -> DONE -> IDLE. N = WIDTH/CHUNK.
//   IDLE: in_ready=1. Edge with in_valid=1: capture a,b,op; y<=0; idx<=0; -> BUSY.
//   BUSY: in_ready=0. Each edge writes y[idx*CHUNK +: CHUNK] from captured operands; idx++.
//     Edge writing idx==N-1: -> DONE, zero<=(full result==0), computed incl. the last chunk.
//   DONE: out_valid=1, in_ready=0; y, zero held stable. Edge with out_ready=1: -> IDLE, out_valid=0.
//     out_ready=0: stay in DONE indefinitely; nothing changes.
//   Latency: out_valid rises N edges after the accepting edge (WIDTH=8, CHUNK=2: 4).
//   Throughput: one op per N+2 cycles. No accept in the cycle of the out handshake;
//     in_ready rises the cycle after it.
//   in_valid while in_ready=0 is ignored. No effect on state or captured operands.
//   Operand changes on a/b/op after acceptance do not affect the result in flight.
//   CHUNK==WIDTH: single BUSY cycle (N=1). CHUNK==1: N=WIDTH.
//   After out handshake: y, zero keep last result until the next accept clears y.
//   out_valid, in_ready, busy, y, zero are all register outputs or pure state decodes.
//   No combinational path from inputs to outputs.
// TESTING
//   1. WIDTH=8,CHUNK=2, a=8'h55,b=8'h33: AND->y=8'h11, OR->8'h77, NOT->8'hAA, NAND->8'hEE, NOR->8'h88.
//      zero=0 in each case. out_valid exactly 4 edges after accept.
//   2. a=b=8'h55: XOR->y=8'h00,zero=1; XNOR->8'hFF,zero=0; PASS a=8'h00->y=0,zero=1.
//   3. Backpressure: out_ready=0 for 5 cycles in DONE -> y,zero,out_valid stable, in_ready=0;
//      in_valid pulses and a/b changes in BUSY/DONE ignored. Result matches the captured operands.
//   4. Reset: assert rst_n=0 mid-BUSY (2nd chunk) -> outputs 0 immediately, without waiting for a clock edge.
//      Release, issue OR 8'hF0|8'h0F -> y=8'hFF.
//   5. Params: CHUNK=1 -> latency 8; CHUNK=8 -> latency 1; XOR 8'hA5^8'h3C=8'h99 in both.
//   6. Streaming: in_valid and out_ready held 1, 3 ops -> accepts spaced N+2=6 cycles.
//      Results in order, no drop or duplicate.

Source files
------------

// File: rtl/logic_seq_if.sv
// Request/response bundle for the chunked bitwise logic engine.
// The master drives the request and out_ready. The slave returns the result and status.
interface logic_seq_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic             busy;

  modport master (output in_valid, op, a, b, out_ready,
                  input  in_ready, out_valid, y, zero, busy);
  modport slave  (input  in_valid, op, a, b, out_ready,
                  output in_ready, out_valid, y, zero, busy);
endinterface

// File: rtl/logic_seq_unit.sv
// Multi-cycle bitwise logic engine: it captures one op, writes CHUNK result bits per BUSY
// cycle, and then holds the registered result until the consumer takes it.
module logic_seq_unit #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  logic_seq_if.slave   bus
);
  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $fatal(1, "logic_seq_unit: CHUNK must divide WIDTH and lie in 1..WIDTH");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, y_q, y_d, res;
  logic             zero_q, zero_d;
  logic [IDXW-1:0]  idx_q, idx_d;

  function automatic logic [WIDTH-1:0] eval_op(input logic [2:0] o,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] z);
    case (o)
      3'b000:  return x & z;
      3'b001:  return x | z;
      3'b010:  return ~x;
      3'b011:  return x ^ z;
      3'b100:  return ~(x & z);
      3'b101:  return ~(x | z);
      3'b110:  return ~(x ^ z);
      default: return x;
    endcase
  endfunction

  // Only captured operands feed the datapath, so input changes after the accept have no effect.
  assign res = eval_op(op_q, a_q, b_q);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y_q;
    zero_d  = zero_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        op_d    = bus.op;
        a_d     = bus.a;
        b_d     = bus.b;
        y_d     = '0;
        idx_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        y_d[int'(idx_q)*CHUNK +: CHUNK] = res[int'(idx_q)*CHUNK +: CHUNK];
        idx_d = idx_q + IDXW'(1);
        if (idx_q == IDXW'(N-1)) begin
          // y_d already holds the last chunk at this point, so the flag covers the whole result.
          zero_d  = (y_d == '0);
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      zero_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      zero_q  <= zero_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.y         = y_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_logic_seq_unit.sv
// Directed bench for logic_seq_unit. It drives three instances (CHUNK=2, 1, 8) that share
// the clock, reset and operands, and it checks each result against hand-computed values.
module tb_logic_seq_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] op;
  logic [7:0] a, b;
  logic       iv[3], ordy[3];
  logic       ir[3], ov[3], zv[3], bz[3];
  logic [7:0] yv[3];
  int checks = 0;
  int errors = 0;

  logic_seq_if #(.WIDTH(8)) if0 ();
  logic_seq_if #(.WIDTH(8)) if1 ();
  logic_seq_if #(.WIDTH(8)) if2 ();

  logic_seq_unit #(.WIDTH(8), .CHUNK(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  logic_seq_unit #(.WIDTH(8), .CHUNK(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  logic_seq_unit #(.WIDTH(8), .CHUNK(8)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  assign if0.op = op; assign if0.a = a; assign if0.b = b;
  assign if1.op = op; assign if1.a = a; assign if1.b = b;
  assign if2.op = op; assign if2.a = a; assign if2.b = b;
  assign if0.in_valid = iv[0]; assign if0.out_ready = ordy[0];
  assign if1.in_valid = iv[1]; assign if1.out_ready = ordy[1];
  assign if2.in_valid = iv[2]; assign if2.out_ready = ordy[2];
  assign ir[0] = if0.in_ready; assign ov[0] = if0.out_valid; assign yv[0] = if0.y;
  assign zv[0] = if0.zero;     assign bz[0] = if0.busy;
  assign ir[1] = if1.in_ready; assign ov[1] = if1.out_valid; assign yv[1] = if1.y;
  assign zv[1] = if1.zero;     assign bz[1] = if1.busy;
  assign ir[2] = if2.in_ready; assign ov[2] = if2.out_valid; assign yv[2] = if2.y;
  assign zv[2] = if2.zero;     assign bz[2] = if2.busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op on instance d, measure the edges from accept to out_valid, then complete the handshake.
  task automatic run_op(input int d, input logic [2:0] o, input logic [7:0] aa,
                        input logic [7:0] bb, input logic [7:0] ey, input logic ez,
                        input int elat, input string tag);
    int lat;
    check({tag, "_rdy"}, {31'd0, ir[d]}, 32'd1);
    op = o; a = aa; b = bb; iv[d] = 1'b1;
    @(posedge clk); #1;
    iv[d] = 1'b0;
    check({tag, "_busy"}, {30'd0, ir[d], bz[d]}, 32'b01);
    lat = 0;
    while (!ov[d] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, elat);
    check({tag, "_y"}, {24'd0, yv[d]}, {24'd0, ey});
    check({tag, "_z"}, {31'd0, zv[d]}, {31'd0, ez});
    ordy[d] = 1'b1;
    @(posedge clk); #1;
    ordy[d] = 1'b0;
    check({tag, "_hs"}, {30'd0, ov[d], ir[d]}, 32'b01);
  endtask

  initial begin
    int lat, k, r, cyc;
    int acc_cyc[3];
    logic [7:0] res[3];
    logic acc, done;
    logic [7:0] yy;
    logic [2:0] s_op[3];
    logic [7:0] s_a[3], s_b[3], s_y[3];

    op = '0; a = '0; b = '0;
    for (int i = 0; i < 3; i++) begin iv[i] = 1'b0; ordy[i] = 1'b0; end

    // Reset state
    #12;
    check("rst_state", {27'd0, ir[0], ov[0], bz[0], zv[0], |yv[0]}, 32'b10000);
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic ops, a=55 b=33
    run_op(0, 3'b000, 8'h55, 8'h33, 8'h11, 1'b0, 4, "and");
    run_op(0, 3'b001, 8'h55, 8'h33, 8'h77, 1'b0, 4, "or");
    run_op(0, 3'b010, 8'h55, 8'h33, 8'hAA, 1'b0, 4, "not");
    run_op(0, 3'b100, 8'h55, 8'h33, 8'hEE, 1'b0, 4, "nand");
    run_op(0, 3'b101, 8'h55, 8'h33, 8'h88, 1'b0, 4, "nor");
    // Equal operands and the zero flag
    run_op(0, 3'b011, 8'h55, 8'h55, 8'h00, 1'b1, 4, "xor0");
    run_op(0, 3'b110, 8'h55, 8'h55, 8'hFF, 1'b0, 4, "xnor");
    run_op(0, 3'b111, 8'h00, 8'h5A, 8'h00, 1'b1, 4, "pass0");

    // Backpressure: AND 0F&3C = 0C. Operand and in_valid activity after the accept must be ignored.
    op = 3'b000; a = 8'h0F; b = 8'h3C; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    op = 3'b001; a = 8'hFF; b = 8'hFF; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    lat = 2;
    while (!ov[0] && lat < 40) begin @(posedge clk); #1; lat++; end
    check("bp_lat", lat, 4);
    for (int i = 0; i < 5; i++) begin
      iv[0] = i[0];
      a = 8'(i);
      @(posedge clk); #1;
      check("bp_hold", {21'd0, ov[0], ir[0], zv[0], yv[0]}, {21'd0, 1'b1, 1'b0, 1'b0, 8'h0C});
    end
    iv[0] = 1'b0; ordy[0] = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b0;
    check("bp_after", {22'd0, ov[0], ir[0], yv[0]}, {22'd0, 1'b0, 1'b1, 8'h0C});

    // Asynchronous reset in the middle of BUSY
    op = 3'b111; a = 8'hC3; b = 8'h00; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    check("mid_busy", {31'd0, bz[0]}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst", {20'd0, ir[0], ov[0], bz[0], zv[0], yv[0]}, {20'd0, 4'b1000, 8'h00});
    @(posedge clk); #1 rst_n = 1'b1;
    run_op(0, 3'b001, 8'hF0, 8'h0F, 8'hFF, 1'b0, 4, "or_post_rst");

    // Parameter corners
    run_op(1, 3'b011, 8'hA5, 8'h3C, 8'h99, 1'b0, 8, "xor_c1");
    run_op(2, 3'b011, 8'hA5, 8'h3C, 8'h99, 1'b0, 1, "xor_c8");

    // Streaming with in_valid and out_ready held high
    s_op[0] = 3'b000; s_a[0] = 8'h55; s_b[0] = 8'h33; s_y[0] = 8'h11;
    s_op[1] = 3'b001; s_a[1] = 8'h55; s_b[1] = 8'h33; s_y[1] = 8'h77;
    s_op[2] = 3'b011; s_a[2] = 8'h55; s_b[2] = 8'h33; s_y[2] = 8'h66;
    k = 0; r = 0; cyc = 0;
    for (int i = 0; i < 3; i++) begin acc_cyc[i] = 0; res[i] = '0; end
    op = s_op[0]; a = s_a[0]; b = s_b[0];
    iv[0] = 1'b1; ordy[0] = 1'b1;
    repeat (30) begin
      acc = ir[0] & iv[0];
      done = ov[0];
      yy = yv[0];
      @(posedge clk); #1;
      cyc++;
      if (acc && k < 3) begin
        acc_cyc[k] = cyc;
        k++;
        if (k < 3) begin op = s_op[k]; a = s_a[k]; b = s_b[k]; end
        else iv[0] = 1'b0;
      end
      if (done && r < 3) begin res[r] = yy; r++; end
      else if (done) r++;
    end
    iv[0] = 1'b0; ordy[0] = 1'b0;
    check("st_accepts", k, 3);
    check("st_results", r, 3);
    check("st_gap01", acc_cyc[1] - acc_cyc[0], 6);
    check("st_gap12", acc_cyc[2] - acc_cyc[1], 6);
    for (int i = 0; i < 3; i++) check("st_y", {24'd0, res[i]}, {24'd0, s_y[i]});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
